alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, max cycles in WAIT before the operation is abandoned.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0, req1  input  1 each  operation request from requester 0/1; held high until matching done.
REQ-005 op0, op1  input  2 each  opcode: 0=ADD, 1=SUB, 2=MUL, 3=NEG.
REQ-006 a0, b0, a1, b1  input  8 each  operands per requester; b ignored for NEG.
REQ-007 alu_en  output  1  enable to the shared ALU multiplexer.
REQ-008 alu_state  output  2  opcode to the ALU.
REQ-009 alu_value1, alu_value2  output  8 each  latched operands to the ALU.
REQ-010 alu_out1, alu_out2  input  8 each  ALU low/high result bytes.
REQ-011 alu_ready  input  1  ALU result-valid.
REQ-012 grant0, grant1  output  1 each  one-cycle pulse: request accepted, operands latched.
REQ-013 done0, done1  output  1 each  one-cycle pulse: result_lo/result_hi valid for that requester.
REQ-014 result_lo, result_hi  output  8 each  captured result; result_hi forced 0 unless op was MUL.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 timeout  output  1  high with done pulse when the operation timed out; result then 0.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, DONE; exactly one active.
REQ-018 IDLE: if any req high, select winner, latch its op/a/b into alu_state/alu_value1/alu_value2, pulse its grant, go ISSUE; else stay.
REQ-019 Arbitration: single requester wins; both high -> the one not served last; last_served resets to 1, so req0 wins the first contention.
REQ-020 ISSUE: alu_en=1 for exactly one cycle, alu_ready ignored (stale), go WAIT.
REQ-021 WAIT: alu_en=1; wait counter increments each cycle; alu_ready=1 -> capture alu_out1 into result_lo, alu_out2 (MUL) or 0 into result_hi, go DONE.
REQ-022 WAIT: counter reaches TIMEOUT_CYCLES with alu_ready low -> results 0, timeout=1, go DONE.
REQ-023 alu_ready and timeout in the same cycle -> alu_ready wins, timeout=0.
REQ-024 DONE: alu_en=0, pulse done of winner, update last_served, go IDLE; alu_en therefore low at least one cycle between operations.
REQ-025 Minimum grant-to-done latency 3 cycles (ISSUE, WAIT with ready, DONE); request-to-grant 1 cycle from IDLE.
REQ-026 Requests arriving while busy are held off, no grant; evaluated at next IDLE.
REQ-027 Winner dropping req mid-operation: operation completes, done still pulsed; no cancel.
REQ-028 alu_state/alu_value1/alu_value2 stable from grant through DONE regardless of input changes.
REQ-029 result_lo/result_hi/timeout hold until next capture.
REQ-030 grant0/grant1 and done0/done1 never high simultaneously.

Reset
REQ-031 reset_n low: state IDLE, all outputs 0, counter 0, last_served=1, immediately and regardless of clk.
REQ-032 Reset mid-operation abandons it; no done pulse issued; alu_en drops asynchronously.

Structure
REQ-033 Shared package holds opcode constants (ADD/SUB/MUL/NEG) and FSM state encoding, also used by the ALU multiplexer.
REQ-034 Single module; round-robin selection may be a sub-module rr_arb2 (2 requests, last_served in, one-hot grant out).

Verification
REQ-035 req0 ADD a0=5 b0=3, ALU ready after 2 WAIT cycles -> grant0 next cycle, done0 with result_lo=8, result_hi=0.
REQ-036 req0 and req1 high same cycle after reset (req0 MUL 12x11, req1 SUB 9-4) -> req0 first result_lo=132 result_hi=0; then req1, result_lo=5; grants alternate.
REQ-037 Both held continuously for 4 operations -> grants 0,1,0,1; alu_en low one cycle between each.
REQ-038 alu_ready never asserted, TIMEOUT_CYCLES=8 -> done pulse 8 WAIT cycles after ISSUE, timeout=1, results 0.
REQ-039 reset_n pulsed low during WAIT -> alu_en, busy 0 immediately, no done; next req granted normally.
REQ-040 Winner drops req and changes a0 during WAIT -> alu_value1 unchanged, done still pulsed with correct result.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter and the ALU multiplexer it drives.
// Holds the opcode encoding seen on op0/op1 and alu_state, and the arbiter FSM encoding.
package alu_arbiter_pkg;

    localparam int unsigned DataW = 8;
    localparam int unsigned OpW   = 2;

    typedef enum logic [OpW-1:0] {
        OpAdd = 2'd0,
        OpSub = 2'd1,
        OpMul = 2'd2,
        OpNeg = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin selector.
// Ports:
//   req         - request vector, bit i from requester i
//   last_served - index of the requester served most recently
//   grant       - one-hot winner, zero when no request is pending
module alu_arbiter_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention: favour whoever was not served last.
            2'b11:   grant = last_served ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU. The winner's opcode and operands are latched
// at grant, held on alu_state/alu_value1/alu_value2, and the result is captured when the ALU
// reports ready or abandoned after TIMEOUT_CYCLES wait cycles.
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   req0/1, op0/1, a0/1, b0/1    - per-requester request, opcode and operands
//   alu_en, alu_state            - ALU enable and opcode
//   alu_value1, alu_value2       - latched operands to the ALU
//   alu_out1, alu_out2, alu_ready- ALU low/high result and result-valid
//   grant0/1, done0/1            - one-cycle acceptance / completion pulses
//   result_lo, result_hi         - captured result (high byte only for MUL)
//   busy, timeout                - not idle / last operation timed out
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    output logic       alu_en,
    output logic [1:0] alu_state,
    output logic [7:0] alu_value1,
    output logic [7:0] alu_value2,
    input  logic [7:0] alu_out1,
    input  logic [7:0] alu_out2,
    input  logic       alu_ready,
    output logic       grant0,
    output logic       grant1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] result_lo,
    output logic [7:0] result_hi,
    output logic       busy,
    output logic       timeout
);

    // Counter holds the index of the current WAIT cycle, 0 .. TIMEOUT_CYCLES-1.
    localparam int unsigned CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [1:0]      arb_grant;
    logic [1:0]      grant_q;
    logic            winner_q;
    logic            last_served_q;
    logic [CntW-1:0] cnt_q;
    op_e             op_q;
    logic [7:0]      value1_q, value2_q;
    logic [7:0]      result_lo_q, result_hi_q;
    logic            timeout_q;

    alu_arbiter_rr_arb2 u_rr_arb2 (
        .req         ({req1, req0}),
        .last_served (last_served_q),
        .grant       (arb_grant)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|arb_grant) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (alu_ready || (cnt_q == CntLast)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs; combinational so reset clears them without a clock.
    always_comb begin
        alu_en = (state_q == StIssue) || (state_q == StWait);
        busy   = (state_q != StIdle);
        done0  = (state_q == StDone) && !winner_q;
        done1  = (state_q == StDone) && winner_q;
    end

    // Operand latch, wait counter, result capture and round-robin history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q       <= 2'b00;
            winner_q      <= 1'b0;
            last_served_q <= 1'b1;
            cnt_q         <= '0;
            op_q          <= OpAdd;
            value1_q      <= '0;
            value2_q      <= '0;
            result_lo_q   <= '0;
            result_hi_q   <= '0;
            timeout_q     <= 1'b0;
        end else begin
            grant_q <= 2'b00;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (|arb_grant) begin
                        grant_q  <= arb_grant;
                        winner_q <= arb_grant[1];
                        op_q     <= arb_grant[1] ? op_e'(op1) : op_e'(op0);
                        value1_q <= arb_grant[1] ? a1 : a0;
                        value2_q <= arb_grant[1] ? b1 : b0;
                    end
                end
                StIssue: cnt_q <= '0;
                StWait: begin
                    // Ready takes priority over an expiring counter in the same cycle.
                    if (alu_ready) begin
                        result_lo_q <= alu_out1;
                        result_hi_q <= (op_q == OpMul) ? alu_out2 : 8'h00;
                        timeout_q   <= 1'b0;
                    end else if (cnt_q == CntLast) begin
                        result_lo_q <= 8'h00;
                        result_hi_q <= 8'h00;
                        timeout_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: last_served_q <= winner_q;
                default: ;
            endcase
        end
    end

    assign grant0     = grant_q[0];
    assign grant1     = grant_q[1];
    assign alu_state  = op_q;
    assign alu_value1 = value1_q;
    assign alu_value2 = value2_q;
    assign result_lo  = result_lo_q;
    assign result_hi  = result_hi_q;
    assign timeout    = timeout_q;

endmodule
